multi_ch_pulse_gen: RTL

MULTI_CH_PULSE_GEN -- requirements
Module: multi_ch_pulse_gen

---
 rtl/multi_ch_pulse_gen.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_ch_pulse_gen.sv
// multi_ch_pulse_gen: CH_NUM independent pulse channels for IGBT gate drive.
// Each channel runs an optional start delay followed by repeating on/off
// periods, optionally limited to a burst count. The host writes the active
// configuration; the running period uses a shadow copy that is refreshed only
// at period boundaries. A shared latched fault stops every channel at once.
module multi_ch_pulse_gen #(
  parameter int CH_NUM = 5,
  parameter int CNT_W  = 24,
  parameter int CH_AW  = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_wr,
  input  logic [CH_AW-1:0]  cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [CNT_W-1:0]  cfg_data,
  input  logic [CH_NUM-1:0] run,
  input  logic              fault,
  input  logic              fault_clr,
  output logic [CH_NUM-1:0] pulse_out,
  output logic [CH_NUM-1:0] busy,
  output logic [CH_NUM-1:0] burst_done,
  output logic              fault_latched
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ON    = 2'd2,
    ST_OFF   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CH_NUM-1:0] run_q_r;
  logic              fault_latched_r;
  logic              halt_s;

  // Previous run level for edge detection; preset high so a run held through reset cannot start a channel
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_q_r <= {CH_NUM{1'b1}};
    end else begin
      run_q_r <= run;
    end
  end

  // Fault latch: fault sets it and dominates a simultaneous clear
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fault_latched_r <= 1'b0;
    end else if (fault) begin
      fault_latched_r <= 1'b1;
    end else if (fault_clr) begin
      fault_latched_r <= 1'b0;
    end else begin
      fault_latched_r <= fault_latched_r;
    end
  end

  // Any live or held fault parks every channel in IDLE
  always_comb begin
    halt_s = fault | fault_latched_r;
  end

  assign fault_latched = fault_latched_r;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    // Channel ids that do not exist never match, so such writes are dropped
    localparam logic [CH_AW-1:0] CH_ID = CH_AW'(g);

    logic [CNT_W-1:0] act_period_r, act_on_r, act_delay_r, act_burst_r;
    logic [CNT_W-1:0] sh_period_r, sh_on_r, sh_delay_r, sh_burst_r;
    logic [CNT_W-1:0] sh_on_eff_s, sh_off_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] rem_r, rem_s;
    state_t           state_r, state_s;
    logic             sh_ld_s, bnd_s, done_s;
    logic             pulse_s, busy_s;
    logic             pulse_r, busy_r, done_r;

    // Active configuration: host writes land here immediately
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        act_period_r <= CNT_ZERO;
        act_on_r     <= CNT_ZERO;
        act_delay_r  <= CNT_ZERO;
        act_burst_r  <= CNT_ZERO;
      end else if (cfg_wr && (cfg_ch == CH_ID)) begin
        case (cfg_sel)
          2'd0:    act_period_r <= cfg_data;
          2'd1:    act_on_r     <= cfg_data;
          2'd2:    act_delay_r  <= cfg_data;
          2'd3:    act_burst_r  <= cfg_data;
          default: act_period_r <= act_period_r;
        endcase
      end
    end

    // High and low lengths of the period being generated, on-time clipped to the period
    always_comb begin
      if (sh_on_r < sh_period_r) begin
        sh_on_eff_s = sh_on_r;
      end else begin
        sh_on_eff_s = sh_period_r;
      end
      sh_off_s = sh_period_r - sh_on_eff_s;
    end

    // Next-state logic: start, delay, on/off phases and period boundary handling
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      rem_s   = rem_r;
      sh_ld_s = 1'b0;
      bnd_s   = 1'b0;
      done_s  = 1'b0;
      if (halt_s || ((state_r != ST_IDLE) && !run[g])) begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (run[g] && !run_q_r[g] && (act_period_r != CNT_ZERO)) begin
              sh_ld_s = 1'b1;
              rem_s   = act_burst_r;
              cnt_s   = CNT_ZERO;
              if (act_delay_r != CNT_ZERO) begin
                state_s = ST_DELAY;
              end else if (act_on_r != CNT_ZERO) begin
                state_s = ST_ON;
              end else begin
                state_s = ST_OFF;
              end
            end else begin
              state_s = ST_IDLE;
            end
          end
          ST_DELAY: begin
            if (cnt_r == (sh_delay_r - CNT_ONE)) begin
              cnt_s = CNT_ZERO;
              if (sh_on_eff_s != CNT_ZERO) begin
                state_s = ST_ON;
              end else begin
                state_s = ST_OFF;
              end
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end
          ST_ON: begin
            if (cnt_r == (sh_on_eff_s - CNT_ONE)) begin
              cnt_s = CNT_ZERO;
              if (sh_off_s != CNT_ZERO) begin
                state_s = ST_OFF;
              end else begin
                bnd_s = 1'b1;
              end
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end
          ST_OFF: begin
            if (cnt_r == (sh_off_s - CNT_ONE)) begin
              bnd_s = 1'b1;
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end
          default: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
          end
        endcase
        // Period boundary: pick up new config, count the burst, choose the next period's first phase
        if (bnd_s) begin
          sh_ld_s = 1'b1;
          cnt_s   = CNT_ZERO;
          if ((sh_burst_r != CNT_ZERO) && (rem_r <= CNT_ONE)) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            if (sh_burst_r != CNT_ZERO) begin
              rem_s = rem_r - CNT_ONE;
            end else begin
              rem_s = rem_r;
            end
            if (act_period_r == CNT_ZERO) begin
              state_s = ST_IDLE;
            end else if (act_on_r != CNT_ZERO) begin
              state_s = ST_ON;
            end else begin
              state_s = ST_OFF;
            end
          end
        end else begin
          done_s = 1'b0;
        end
      end
    end

    // Output decode from the next state so the registered outputs line up with the state
    always_comb begin
      pulse_s = (state_s == ST_ON);
      busy_s  = (state_s != ST_IDLE);
    end

    // State, counters, shadow configuration and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state_r     <= ST_IDLE;
        cnt_r       <= CNT_ZERO;
        rem_r       <= CNT_ZERO;
        sh_period_r <= CNT_ZERO;
        sh_on_r     <= CNT_ZERO;
        sh_delay_r  <= CNT_ZERO;
        sh_burst_r  <= CNT_ZERO;
        pulse_r     <= 1'b0;
        busy_r      <= 1'b0;
        done_r      <= 1'b0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        rem_r   <= rem_s;
        if (sh_ld_s) begin
          sh_period_r <= act_period_r;
          sh_on_r     <= act_on_r;
          sh_delay_r  <= act_delay_r;
          sh_burst_r  <= act_burst_r;
        end
        pulse_r <= pulse_s;
        busy_r  <= busy_s;
        done_r  <= done_s;
      end
    end

    assign pulse_out[g]  = pulse_r;
    assign busy[g]       = busy_r;
    assign burst_done[g] = done_r;
  end

endmodule
